// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state/owner types and memory direction constants for the memory port arbiter
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam logic MEM_READ = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: DM-priority grant with a DM streak counter that forces an IF grant after MAX_DM_STREAK
module mem_arb_pick #(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DM_STREAK);
  logic [SW-1:0] streak;
  logic if_first;
  always_comb begin
    if_first = if_req && (!dm_req || streak == SMAX);
    if_gnt = arb && if_first;
    dm_gnt = arb && dm_req && !if_first;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak <= '0;
    else if (dm_gnt) streak <= !if_req ? '0 : (streak == SMAX ? SMAX : streak + 1'b1);
    else if (if_gnt) streak <= '0;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data accesses with fixed read latency
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LAT = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  state_t state;
  owner_t own;
  logic we;
  logic [7:0] cnt;
  logic idle;
  assign idle = state == IDLE;
  assign mem_en = state == ACCESS;
  assign mem_rw = mem_en && we == MEM_WRITE;
  assign busy = !idle;
  mem_arb_pick #(.MAX_DM_STREAK(MAX_DM_STREAK)) u_pick (
    .clk(clk),
    .rst(rst),
    .arb(idle),
    .if_req(if_req),
    .dm_req(dm_req),
    .if_gnt(if_gnt),
    .dm_gnt(dm_gnt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      own <= OWN_IF;
      we <= MEM_READ;
      cnt <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      dm_done <= 1'b0;
      if_instr <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_done <= 1'b0;
      case (state)
        IDLE: if (if_gnt || dm_gnt) begin
          state <= ACCESS;
          own <= dm_gnt ? OWN_DM : OWN_IF;
          we <= dm_gnt ? dm_we : MEM_READ;
          mem_addr <= dm_gnt ? dm_addr : if_addr;
          if (dm_gnt) mem_wdata <= dm_wdata;
          cnt <= 8'(LAT - 1);
        end
        ACCESS: if (cnt == 8'd0) begin
          state <= DONE;
          if_valid <= own == OWN_IF;
          dm_done <= own == OWN_DM;
          if (own == OWN_IF) if_instr <= mem_rdata;
          if (own == OWN_DM && we == MEM_READ) dm_rdata <= mem_rdata;
        end else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus corner-case sequences for the memory port arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic if_gnt, if_valid, dm_gnt, dm_done, mem_en, mem_rw, busy;
  logic [31:0] if_instr, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_req3, dm_req3, dm_we3;
  logic [31:0] if_addr3, dm_addr3, dm_wdata3;
  logic if_gnt3, if_valid3, dm_gnt3, dm_done3, mem_en3, mem_rw3, busy3;
  logic [31:0] if_instr3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic ifr;
    logic [31:0] ifa;
    logic dmr;
    logic dwe;
    logic [31:0] dma;
    logic [31:0] dmw;
    logic [6:0] e;
    logic [31:0] maddr;
    logic [31:0] instr;
    logic [31:0] rdata;
  } vec_t;
  vec_t v [18];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .MAX_DM_STREAK(4)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_instr(if_instr), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_done(dm_done),
    .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(3), .MAX_DM_STREAK(4)) dut3 (
    .clk(clk), .rst(rst), .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_valid(if_valid3), .if_instr(if_instr3), .dm_req(dm_req3), .dm_we(dm_we3),
    .dm_addr(dm_addr3), .dm_wdata(dm_wdata3), .dm_gnt(dm_gnt3), .dm_done(dm_done3),
    .dm_rdata(dm_rdata3), .mem_en(mem_en3), .mem_rw(mem_rw3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'h0;
      mem1[1] <= 32'h2008_0005;
      mem1[2] <= 32'h8C09_0010;
    end else if (mem_en && mem_rw) mem1[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem1[mem_addr[7:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem3[i] <= 32'h0;
      mem3[8] <= 32'hCAFE_F00D;
    end else if (mem_en3 && mem_rw3) mem3[mem_addr3[7:2]] <= mem_wdata3;
  end
  assign mem_rdata3 = mem3[mem_addr3[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ifr, input logic [31:0] ifa, input logic dmr,
                              input logic dwe, input logic [31:0] dma, input logic [31:0] dmw,
                              input logic [6:0] e, input logic [31:0] maddr,
                              input logic [31:0] instr, input logic [31:0] rdata);
    vec_t r;
    r.ifr = ifr; r.ifa = ifa; r.dmr = dmr; r.dwe = dwe; r.dma = dma; r.dmw = dmw;
    r.e = e; r.maddr = maddr; r.instr = instr; r.rdata = rdata;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string order;
    int n, last, cyc;
    logic [31:0] w = 32'h0;
    logic [31:0] instr_a = 32'h2008_0005;
    logic [31:0] instr_b = 32'h8C09_0010;
    logic [31:0] sd = 32'h1234_5678;
    // e = {if_gnt, dm_gnt, mem_en, mem_rw, if_valid, dm_done, busy}
    v[0]  = mk(1'b1, 32'h4, 1'b0, 1'b0, w, w, 7'b1000000, w, w, w);
    v[1]  = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0010001, 32'h4, w, w);
    v[2]  = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000101, 32'h4, instr_a, w);
    v[3]  = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000000, 32'h4, instr_a, w);
    v[4]  = mk(1'b1, 32'h8, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 7'b0100000, 32'h4, instr_a, w);
    v[5]  = mk(1'b1, 32'h8, 1'b0, 1'b0, w, w, 7'b0011001, 32'h10, instr_a, w);
    v[6]  = mk(1'b1, 32'h8, 1'b0, 1'b0, w, w, 7'b0000011, 32'h10, instr_a, w);
    v[7]  = mk(1'b1, 32'h8, 1'b0, 1'b0, w, w, 7'b1000000, 32'h10, instr_a, w);
    v[8]  = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0010001, 32'h8, instr_a, w);
    v[9]  = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000101, 32'h8, instr_b, w);
    v[10] = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000000, 32'h8, instr_b, w);
    v[11] = mk(1'b0, w, 1'b1, 1'b1, 32'h8, sd, 7'b0100000, 32'h8, instr_b, w);
    v[12] = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0011001, 32'h8, instr_b, w);
    v[13] = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000011, 32'h8, instr_b, w);
    v[14] = mk(1'b0, w, 1'b1, 1'b0, 32'h8, w, 7'b0100000, 32'h8, instr_b, w);
    v[15] = mk(1'b0, w, 1'b1, 1'b1, 32'h30, 32'hFFFF, 7'b0010001, 32'h8, instr_b, w);
    v[16] = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000011, 32'h8, instr_b, sd);
    v[17] = mk(1'b0, w, 1'b0, 1'b0, w, w, 7'b0000000, 32'h8, instr_b, sd);
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0; dm_req3 = 1'b0; dm_we3 = 1'b0; dm_addr3 = '0; dm_wdata3 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 32'({if_gnt, dm_gnt, mem_en, mem_rw, if_valid, dm_done, busy}), 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_instr", if_instr, 0);
    chk("reset_rdata", dm_rdata, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if_req = v[i].ifr; if_addr = v[i].ifa; dm_req = v[i].dmr; dm_we = v[i].dwe;
      dm_addr = v[i].dma; dm_wdata = v[i].dmw;
      #1;
      chk($sformatf("v%0d_ctl", i), 32'({if_gnt, dm_gnt, mem_en, mem_rw, if_valid, dm_done, busy}), 32'(v[i].e));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].maddr);
      chk($sformatf("v%0d_if_instr", i), if_instr, v[i].instr);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, v[i].rdata);
    end
    chk("store_deadbeef", mem1[4], 32'hDEAD_BEEF);
    chk("store_12345678", mem1[2], sd);
    // both requesters held: DM wins four times in a row, then IF is forced
    order = "DDDDIDDDDI";
    n = 0; last = -1; cyc = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
    while (n < 10 && cyc < 60) begin
      #1;
      if (if_gnt || dm_gnt) begin
        chk($sformatf("order%0d", n), 32'(dm_gnt), 32'(order[n] == "D"));
        if (last >= 0) chk($sformatf("spacing%0d", n), cyc - last, 3);
        last = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("order_count", n, 10);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("order_idle", 32'(busy), 0);
    // reset in the middle of a DM store
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h14; dm_wdata = 32'hA5A5_A5A5;
    #1 chk("rst_gnt", 32'(dm_gnt), 1);
    @(negedge clk) dm_req = 1'b0;
    #1 chk("rst_pre_en_rw", 32'({mem_en, mem_rw}), 3);
    #2 rst = 1'b1;
    #1 chk("rst_en_rw_busy", 32'({mem_en, mem_rw, busy}), 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("rst_no_done%0d", k), 32'({dm_done, busy}), 0);
      @(negedge clk);
    end
    chk("rst_no_write", mem1[5], 0);
    // LAT=3 load from 0x20
    dm_req3 = 1'b1; dm_we3 = 1'b0; dm_addr3 = 32'h20;
    #1 chk("lat3_gnt", 32'(dm_gnt3), 1);
    @(negedge clk) dm_req3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lat3_en%0d", k), 32'({mem_en3, mem_rw3, dm_done3}), 32'b100);
      chk($sformatf("lat3_addr%0d", k), mem_addr3, 32'h20);
      @(negedge clk);
    end
    #1;
    chk("lat3_done", 32'({mem_en3, dm_done3, busy3}), 32'b011);
    chk("lat3_rdata", dm_rdata3, 32'hCAFE_F00D);
    @(negedge clk);
    #1 chk("lat3_idle", 32'({dm_done3, busy3}), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
